// File: rtl/multi_shake_detect.sv
// Multi-channel shake detector: per-channel peak-to-peak swing over a fixed sample
// window, thresholded, with consecutive-window hysteresis on the alarm.
module multi_shake_detect #(
   parameter int CH      = 4,
   parameter int DW      = 16,
   parameter int WIN_LEN = 64,
   parameter int HIT_CNT = 3,
   parameter int CLR_CNT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             detect_enable,
   input  logic [DW-1:0]    threshold,
   input  logic [CH*DW-1:0] ch_data,
   input  logic [CH-1:0]    ch_data_en,
   input  logic             alarm_clear,
   output logic [CH-1:0]    ch_alarm,
   output logic [CH-1:0]    ch_alarm_sticky,
   output logic [CH-1:0]    ch_event,
   output logic [CH*DW-1:0] ch_swing
);

   localparam int CW = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
   localparam int HW = $clog2(HIT_CNT + 1);
   localparam int QW = $clog2(CLR_CNT + 1);

   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(WIN_LEN - 1);
   localparam logic [HW-1:0] HIT_ZERO  = HW'(0);
   localparam logic [HW-1:0] HIT_ONE   = HW'(1);
   localparam logic [HW-1:0] HIT_MAX   = HW'(HIT_CNT);
   localparam logic [QW-1:0] QUIET_ZERO = QW'(0);
   localparam logic [QW-1:0] QUIET_ONE  = QW'(1);
   localparam logic [QW-1:0] QUIET_MAX  = QW'(CLR_CNT);

   for (genvar k = 0; k < CH; k++) begin : g_ch
      logic [CW-1:0] cnt_q, cnt_d;
      logic [DW-1:0] min_q, min_d, max_q, max_d, swing_q, swing_d;
      logic          done_q, done_d;       // min/max hold a completed window
      logic          cmp_vld_q, cmp_vld_d; // cmp_hit_q holds a fresh verdict
      logic          cmp_hit_q, cmp_hit_d;
      logic [HW-1:0] hit_q, hit_d;
      logic [QW-1:0] quiet_q, quiet_d;
      logic          alarm_q, alarm_d, event_q, event_d, sticky_q, sticky_d;
      logic [DW-1:0] sample_s, diff_s;

      assign sample_s = ch_data[k*DW +: DW];
      assign diff_s   = max_q - min_q;

      // Next-state for window accumulation, swing/compare pipeline and hysteresis.
      always_comb begin
         cnt_d     = cnt_q;
         min_d     = min_q;
         max_d     = max_q;
         swing_d   = swing_q;
         done_d    = 1'b0;
         cmp_vld_d = 1'b0;
         cmp_hit_d = 1'b0;
         hit_d     = hit_q;
         quiet_d   = quiet_q;
         alarm_d   = alarm_q;
         event_d   = 1'b0;
         if (!detect_enable) begin
            cnt_d   = CNT_ZERO;
            min_d   = {DW{1'b0}};
            max_d   = {DW{1'b0}};
            hit_d   = HIT_ZERO;
            quiet_d = QUIET_ZERO;
            alarm_d = 1'b0;
         end else begin
            if (ch_data_en[k]) begin
               if (cnt_q == CNT_ZERO) begin
                  min_d = sample_s;
                  max_d = sample_s;
               end else begin
                  min_d = (sample_s < min_q) ? sample_s : min_q;
                  max_d = (sample_s > max_q) ? sample_s : max_q;
               end
               if (cnt_q == CNT_LAST) begin
                  cnt_d  = CNT_ZERO;
                  done_d = 1'b1;
               end else begin
                  cnt_d  = cnt_q + CNT_ONE;
               end
            end else begin
               cnt_d = cnt_q;
            end

            if (done_q) begin
               swing_d   = diff_s;
               cmp_vld_d = 1'b1;
               cmp_hit_d = (diff_s > threshold);
            end else begin
               swing_d   = swing_q;
            end

            if (cmp_vld_q) begin
               if (cmp_hit_q) begin
                  quiet_d = QUIET_ZERO;
                  hit_d   = (hit_q == HIT_MAX) ? hit_q : hit_q + HIT_ONE;
               end else begin
                  hit_d   = HIT_ZERO;
                  quiet_d = (quiet_q == QUIET_MAX) ? quiet_q : quiet_q + QUIET_ONE;
               end
               if (hit_d == HIT_MAX) begin
                  alarm_d = 1'b1;
               end else if (quiet_d == QUIET_MAX) begin
                  alarm_d = 1'b0;
               end else begin
                  alarm_d = alarm_q;
               end
            end else begin
               alarm_d = alarm_q;
            end
            event_d = alarm_d & ~alarm_q;
         end
         // A same-cycle event beats alarm_clear.
         sticky_d = event_d | (sticky_q & ~alarm_clear);
      end

      // Channel state registers with synchronous reset.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q     <= CNT_ZERO;
            min_q     <= {DW{1'b0}};
            max_q     <= {DW{1'b0}};
            swing_q   <= {DW{1'b0}};
            done_q    <= 1'b0;
            cmp_vld_q <= 1'b0;
            cmp_hit_q <= 1'b0;
            hit_q     <= HIT_ZERO;
            quiet_q   <= QUIET_ZERO;
            alarm_q   <= 1'b0;
            event_q   <= 1'b0;
            sticky_q  <= 1'b0;
         end else begin
            cnt_q     <= cnt_d;
            min_q     <= min_d;
            max_q     <= max_d;
            swing_q   <= swing_d;
            done_q    <= done_d;
            cmp_vld_q <= cmp_vld_d;
            cmp_hit_q <= cmp_hit_d;
            hit_q     <= hit_d;
            quiet_q   <= quiet_d;
            alarm_q   <= alarm_d;
            event_q   <= event_d;
            sticky_q  <= sticky_d;
         end
      end

      assign ch_alarm[k]            = alarm_q;
      assign ch_event[k]            = event_q;
      assign ch_alarm_sticky[k]     = sticky_q;
      assign ch_swing[k*DW +: DW]   = swing_q;
   end

endmodule
